game_ctrl: RTL and testbench

Top-level Breakout game sequencer: owns the game state machine, the lives counter, the 2-digit BCD score and, optionally, the level number. It sits between the VGA frame timing and the ball/bar/block instances. It gates ball motion, issues respawn and block-restart pulses, and arbitrates simultaneous block-hit events into a single serialized score stream.

---
 rtl/game_pkg.sv | 20 ++
 rtl/game_ctrl_bcd_score.sv | 57 +++++
 rtl/game_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_game_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and field widths for the Breakout game sequencer.
// Exports game_state_e (IDLE..OVER) and the SCORE/LIVES/LEVEL/FRAME counter widths.
// Imported by game_ctrl and bcd_score.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE   = 3'd1,
    PLAY    = 3'd2,
    DYING   = 3'd3,
    CLEARED = 3'd4,
    OVER    = 3'd5
  } game_state_e;

  localparam int SCORE_W     = 8;
  localparam int LIVES_W     = 2;
  localparam int LEVEL_W     = 4;
  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/game_ctrl_bcd_score.sv
// bcd_score: saturating two-digit BCD accumulator.
// Latency: one cycle from clr/add_en to score_bcd; clr wins over add_en.
// Ports: clock, reset (async active-low), clr, add_en (adds POINTS), score_bcd [7:4] tens.
module bcd_score
  import game_pkg::*;
#(
  parameter int POINTS = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               add_en,
  output logic [SCORE_W-1:0] score_bcd
);

  localparam logic [4:0] PTS = 5'(POINTS);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [4:0] ones_sum;
  logic       carry;

  always_comb begin
    ones_d   = ones_q;
    tens_d   = tens_q;
    ones_sum = {1'b0, ones_q} + PTS;
    carry    = (ones_sum >= 5'd10);
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (add_en) begin
      if (carry && (tens_q == 4'd9)) begin
        // Carry out of the tens digit: pin at 99 instead of wrapping.
        ones_d = 4'd9;
        tens_d = 4'd9;
      end else if (carry) begin
        ones_d = 4'(ones_sum - 5'd10);
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_sum[3:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign score_bcd = {tens_q, ones_q};

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: Breakout game sequencer (state machine, lives, BCD score, level, hit arbiter).
// Inputs: clock, reset (async active-low), start level, frame_tick, hit_block/block_exist, endgame pulses.
// Outputs (all registered): state, ball_run, respawn, block_restart, hit_grant, lives, score_bcd,
// level, game_over, level_clear. Optional macro GAME_CTRL_LEVELS_EN enables multi-level play.
module game_ctrl
  import game_pkg::*;
#(
  parameter int N_BLOCKS     = 5,
  parameter int LIVES_INIT   = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int DYING_FRAMES = 90,
  parameter int POINTS       = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                frame_tick,
  input  logic [N_BLOCKS-1:0] hit_block,
  input  logic [N_BLOCKS-1:0] block_exist,
  input  logic                endgame_ball,
  input  logic                endgame_block,
  output logic [2:0]          state,
  output logic                ball_run,
  output logic                respawn,
  output logic                block_restart,
  output logic [N_BLOCKS-1:0] hit_grant,
  output logic [LIVES_W-1:0]  lives,
  output logic [SCORE_W-1:0]  score_bcd,
  output logic [LEVEL_W-1:0]  level,
  output logic                game_over,
  output logic                level_clear
);

  localparam int                     PTR_W      = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
  localparam logic [LIVES_W-1:0]     LIVES_RST  = LIVES_W'(LIVES_INIT);
  localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] DYING_LAST = FRAME_CNT_W'(DYING_FRAMES - 1);

  game_state_e             state_q, state_d;
  logic                    start_q, start_d;
  logic                    ball_run_q, ball_run_d;
  logic                    respawn_q, respawn_d;
  logic                    block_restart_q, block_restart_d;
  logic                    game_over_q, game_over_d;
  logic                    level_clear_q, level_clear_d;
  logic [LIVES_W-1:0]      lives_q, lives_d;
  logic [FRAME_CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_BLOCKS-1:0]     pending_q, pending_d;
  logic [N_BLOCKS-1:0]     hit_grant_q, hit_grant_d;
  logic [PTR_W-1:0]        rr_q, rr_d;
`ifdef GAME_CTRL_LEVELS_EN
  logic [LEVEL_W-1:0]      level_q, level_d;
`endif

  logic                    game_start;
  logic [N_BLOCKS-1:0]     pend_set;
  logic                    found;
  int                      idx;
  int                      win;
  logic [PTR_W-1:0]        idx_v;

  assign start_d = start;

  // Game state machine.
  always_comb begin
    state_d         = state_q;
    lives_d         = lives_q;
    cnt_d           = cnt_q;
    respawn_d       = 1'b0;
    block_restart_d = 1'b0;
    game_start      = 1'b0;
`ifdef GAME_CTRL_LEVELS_EN
    level_d         = level_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !start_q) begin
          state_d         = SERVE;
          game_start      = 1'b1;
          lives_d         = LIVES_RST;
          respawn_d       = 1'b1;
          block_restart_d = 1'b1;
`ifdef GAME_CTRL_LEVELS_EN
          level_d         = '0;
`endif
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) state_d = PLAY;
          else                     cnt_d   = cnt_q + 1'b1;
        end
      end
      PLAY: begin
        if (endgame_block) begin
          state_d = OVER;
        end else if (endgame_ball) begin
          if (lives_q == LIVES_W'(1)) begin
            state_d = OVER;
            lives_d = '0;
          end else begin
            state_d = DYING;
            lives_d = lives_q - 1'b1;
          end
        end else if ((block_exist == '0) && (pending_q == '0)) begin
          state_d = CLEARED;
        end
      end
      DYING: begin
        if (frame_tick) begin
          if (cnt_q == DYING_LAST) begin
            state_d   = SERVE;
            respawn_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CLEARED: begin
`ifdef GAME_CTRL_LEVELS_EN
        if (frame_tick) begin
          state_d         = SERVE;
          respawn_d       = 1'b1;
          block_restart_d = 1'b1;
          if (level_q != '1) level_d = level_q + 1'b1;
        end
`endif
      end
      OVER: begin
      end
      default: state_d = IDLE;
    endcase

    // Dropping start aborts any game; score and lives stay frozen for display.
    if ((state_q != IDLE) && !start) begin
      state_d         = IDLE;
      lives_d         = lives_q;
      respawn_d       = 1'b0;
      block_restart_d = 1'b0;
`ifdef GAME_CTRL_LEVELS_EN
      level_d         = level_q;
`endif
    end

    if (state_d != state_q) cnt_d = '0;

    ball_run_d    = (state_d == PLAY);
    game_over_d   = (state_d == OVER);
    level_clear_d = (state_d == CLEARED);
  end

  // Round-robin hit arbiter: one grant per cycle, search starts at rr_q and wraps.
  always_comb begin
    pend_set    = (state_q == PLAY) ? hit_block : '0;
    hit_grant_d = '0;
    found       = 1'b0;
    win         = 0;
    idx         = 0;
    idx_v       = '0;
    for (int i = 0; i < N_BLOCKS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_BLOCKS) idx = idx - N_BLOCKS;
      idx_v = PTR_W'(idx);
      if (!found && pending_q[idx_v]) begin
        found              = 1'b1;
        hit_grant_d[idx_v] = 1'b1;
        win                = idx;
      end
    end
    rr_d = rr_q;
    if (found) rr_d = (win == N_BLOCKS - 1) ? '0 : PTR_W'(win + 1);
    // A fresh hit on the bit being granted re-arms it (set after clear).
    if (game_start) pending_d = '0;
    else            pending_d = (pending_q & ~hit_grant_d) | pend_set;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      // Treat start as already high out of reset so a held switch needs a fresh 0->1 edge.
      start_q         <= 1'b1;
      ball_run_q      <= 1'b0;
      respawn_q       <= 1'b0;
      block_restart_q <= 1'b0;
      game_over_q     <= 1'b0;
      level_clear_q   <= 1'b0;
      lives_q         <= LIVES_RST;
      cnt_q           <= '0;
      pending_q       <= '0;
      hit_grant_q     <= '0;
      rr_q            <= '0;
    end else begin
      state_q         <= state_d;
      start_q         <= start_d;
      ball_run_q      <= ball_run_d;
      respawn_q       <= respawn_d;
      block_restart_q <= block_restart_d;
      game_over_q     <= game_over_d;
      level_clear_q   <= level_clear_d;
      lives_q         <= lives_d;
      cnt_q           <= cnt_d;
      pending_q       <= pending_d;
      hit_grant_q     <= hit_grant_d;
      rr_q            <= rr_d;
    end
  end

`ifdef GAME_CTRL_LEVELS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) level_q <= '0;
    else        level_q <= level_d;
  end
  assign level = level_q;
`else
  assign level = '0;
`endif

  bcd_score #(.POINTS(POINTS)) u_score (
    .clock     (clock),
    .reset     (reset),
    .clr       (game_start),
    .add_en    (found),
    .score_bcd (score_bcd)
  );

  assign state         = state_q;
  assign ball_run      = ball_run_q;
  assign respawn       = respawn_q;
  assign block_restart = block_restart_q;
  assign hit_grant     = hit_grant_q;
  assign lives         = lives_q;
  assign game_over     = game_over_q;
  assign level_clear   = level_clear_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed self-checking bench for game_ctrl with a grant/score scoreboard.
module tb_game_ctrl;
  import game_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       frame_tick;
  logic [4:0] hit_block;
  logic [4:0] block_exist;
  logic       endgame_ball;
  logic       endgame_block;
  logic [2:0] state;
  logic       ball_run, respawn, block_restart, game_over, level_clear;
  logic [4:0] hit_grant;
  logic [1:0] lives;
  logic [7:0] score_bcd;
  logic [3:0] level;

  int n_cmp = 0;
  int n_err = 0;
  int exp_score = 0;

  typedef struct {
    logic [4:0] g;
    logic [7:0] s;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  game_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .frame_tick(frame_tick),
    .hit_block(hit_block), .block_exist(block_exist),
    .endgame_ball(endgame_ball), .endgame_block(endgame_block),
    .state(state), .ball_run(ball_run), .respawn(respawn), .block_restart(block_restart),
    .hit_grant(hit_grant), .lives(lives), .score_bcd(score_bcd), .level(level),
    .game_over(game_over), .level_clear(level_clear)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int s);
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic new_game();
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    cyc();
    frames(60);
  endtask

  task automatic die(input int exp_lives);
    endgame_ball = 1'b1;
    cyc();
    endgame_ball = 1'b0;
    chk("die_state", 32'(state), 32'(DYING));
    chk("die_lives", 32'(lives), 32'(exp_lives));
    chk("die_ball_run", 32'(ball_run), 32'd0);
    frames(89);
    chk("dying_hold", 32'(state), 32'(DYING));
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("respawn_state", 32'(state), 32'(SERVE));
    chk("respawn_pulse", 32'(respawn), 32'd1);
    chk("respawn_no_restart", 32'(block_restart), 32'd0);
    cyc();
    chk("respawn_end", 32'(respawn), 32'd0);
    frames(60);
    chk("replay_state", 32'(state), 32'(PLAY));
  endtask

  // Scoreboard monitor: every grant must match the next expected grant and score.
  always @(negedge clock) begin
    if (reset === 1'b1 && hit_grant !== 5'd0) begin
      if (sb.size() == 0) begin
        chk("unexpected_grant", 32'(hit_grant), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_grant", 32'(hit_grant), 32'(mon_e.g));
        chk("sb_score", 32'(score_bcd), 32'(mon_e.s));
      end
    end
  end

  initial begin
    reset = 1'b0; start = 1'b1; frame_tick = 1'b0; hit_block = '0;
    block_exist = '1; endgame_ball = 1'b0; endgame_block = 1'b0;
    repeat (3) cyc();
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_score", 32'(score_bcd), 32'h00);
    chk("rst_ball_run", 32'(ball_run), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    reset = 1'b1;
    repeat (3) cyc();
    chk("held_start_idle", 32'(state), 32'(IDLE));

    // Start edge.
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    chk("start_state", 32'(state), 32'(SERVE));
    chk("start_respawn", 32'(respawn), 32'd1);
    chk("start_restart", 32'(block_restart), 32'd1);
    cyc();
    chk("start_respawn_end", 32'(respawn), 32'd0);
    chk("start_restart_end", 32'(block_restart), 32'd0);
    frames(59);
    chk("serve_hold", 32'(state), 32'(SERVE));
    chk("serve_ball_run", 32'(ball_run), 32'd0);
    frames(1);
    chk("play_state", 32'(state), 32'(PLAY));
    chk("play_ball_run", 32'(ball_run), 32'd1);

    // Three simultaneous hits, granted in round-robin order on consecutive cycles.
    hit_block = 5'b10101;
    sb.push_back('{5'b00001, to_bcd(1)});
    sb.push_back('{5'b00100, to_bcd(2)});
    sb.push_back('{5'b10000, to_bcd(3)});
    exp_score = 3;
    cyc();
    hit_block = '0;
    chk("hit_lat_t1", 32'(hit_grant), 32'd0);
    cyc();
    chk("hit_g0", 32'(hit_grant), 32'b00001);
    cyc();
    chk("hit_g2", 32'(hit_grant), 32'b00100);
    cyc();
    chk("hit_g4", 32'(hit_grant), 32'b10000);
    cyc();
    chk("hit_idle", 32'(hit_grant), 32'd0);
    chk("hit_sb_empty", 32'(sb.size()), 32'd0);
    chk("score_03", 32'(score_bcd), 32'h03);

    // Saturation: push score past 99.
    for (int k = 0; k < 100; k++) begin
      hit_block = 5'b00001;
      exp_score = (exp_score < 99) ? exp_score + 1 : 99;
      sb.push_back('{5'b00001, to_bcd(exp_score)});
      cyc();
      hit_block = '0;
      cyc();
      cyc();
    end
    repeat (3) cyc();
    chk("sat_sb_empty", 32'(sb.size()), 32'd0);
    chk("score_sat", 32'(score_bcd), 32'h99);

    // Lose all lives.
    die(2);
    die(1);
    endgame_ball = 1'b1;
    cyc();
    endgame_ball = 1'b0;
    chk("over_state", 32'(state), 32'(OVER));
    chk("over_lives", 32'(lives), 32'd0);
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_ball_run", 32'(ball_run), 32'd0);

    // Abort keeps display values; new game clears them.
    start = 1'b0;
    cyc();
    chk("abort_idle", 32'(state), 32'(IDLE));
    chk("abort_score_kept", 32'(score_bcd), 32'h99);
    start = 1'b1;
    cyc();
    chk("g2_score_clr", 32'(score_bcd), 32'h00);
    chk("g2_lives", 32'(lives), 32'd3);
    cyc();
    frames(60);
    chk("g2_play", 32'(state), 32'(PLAY));
    endgame_ball = 1'b1;
    endgame_block = 1'b1;
    cyc();
    endgame_ball = 1'b0;
    endgame_block = 1'b0;
    chk("both_over", 32'(state), 32'(OVER));
    chk("both_lives", 32'(lives), 32'd3);

    // Level clear.
    new_game();
    chk("g3_play", 32'(state), 32'(PLAY));
    block_exist = '0;
    cyc();
    chk("cleared_state", 32'(state), 32'(CLEARED));
    chk("cleared_flag", 32'(level_clear), 32'd1);
    chk("cleared_ball_run", 32'(ball_run), 32'd0);
`ifdef GAME_CTRL_LEVELS_EN
    frame_tick = 1'b1;
    block_exist = '1;
    cyc();
    frame_tick = 1'b0;
    chk("lvl_serve", 32'(state), 32'(SERVE));
    chk("lvl_level", 32'(level), 32'd1);
    chk("lvl_restart", 32'(block_restart), 32'd1);
    cyc();
    chk("lvl_restart_end", 32'(block_restart), 32'd0);
    chk("lvl_lives", 32'(lives), 32'd3);
`else
    frames(3);
    chk("cleared_hold", 32'(state), 32'(CLEARED));
    chk("cleared_level0", 32'(level), 32'd0);
`endif
    start = 1'b0;
    cyc();
    chk("end_idle", 32'(state), 32'(IDLE));

    // Hits outside PLAY are dropped.
    hit_block = '1;
    cyc();
    hit_block = '0;
    repeat (4) cyc();
    chk("drop_no_grant", 32'(hit_grant), 32'd0);
    chk("drop_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
